moy_checker: RTL and testbench
==============================

# moy_checker

Self-checking monitor for the moving-average filter's output stream. It samples the filter input `e` and output `m` on each valid clock edge and keeps its own TAPS-deep history of `e`. It compares `m` against a reference average computed from that history and reports mismatches through a sticky flag, saturating counters and a first-error capture. It sits in the test environment next to the sample generator and the filter, on the filter's output side.

## Interface
- `WIDTH`, 8, sample width of `e` and `m`.
- `TAPS`, 4, averaging depth; power of two, 2..16.
- `CW`, 16, width of `chk_cnt` and `err_cnt`.
---
- `clk`, in, 1, clock.
- `nrst`, in, 1, reset, asynchronous, active-low.
- `en`, in, 1, checking enable.
- `vld`, in, 1, `e` and `m` valid on this edge.
- `clr`, in, 1, synchronous clear of result registers.
- `e`, in, WIDTH, filter input sample.
- `m`, in, WIDTH, filter output sample.
- `state`, out, 2, FSM state: 0 IDLE, 1 FILL, 2 CHECK.
- `err`, out, 1, sticky mismatch flag.
- `chk_cnt`, out, CW, number of comparisons made, saturating.
- `err_cnt`, out, CW, number of mismatches, saturating.
- `first_exp`, out, WIDTH, expected value at the first mismatch.
- `first_got`, out, WIDTH, `m` value at the first mismatch.

## Operation
- **History:** registers h0..h(TAPS-1).
  - On every edge with `vld=1` and state ≠ IDLE, history shifts: h0←`e`, hk←h(k-1).
  - The history is not reset; it is don't-care until filled.
- **Expected value:** `exp = sum(h)>>log2(TAPS)`.
  - Sum width is WIDTH+log2(TAPS); no overflow.
  - Taken from the history before the shift on the same edge, which matches a filter that registers `e` and averages combinationally.
- **FSM:**
  - IDLE→FILL on an edge with `en=1`; `fill_cnt` is cleared at this point.
  - In FILL, `fill_cnt` increments on each `vld` edge. When the TAPS-th valid sample is shifted in, FILL→CHECK. No compare occurs in FILL.
  - In CHECK, every `vld` edge performs a compare:
    - `chk_cnt` increments.
    - On `m≠exp`: `err`←1 and `err_cnt` increments.
    - If this is the first error since reset/`clr`, `first_exp`←exp and `first_got`←`m`.
  - `en=0` from any state →IDLE on that edge. No shift and no compare happen on that edge. A later `en=1` restarts FILL from zero.
- **clr:**
  - Zeroes `err`, `chk_cnt`, `err_cnt`, `first_exp`, `first_got` and re-arms first-error capture.
  - Does not change state, history or `fill_cnt`.
  - `clr` and a compare on the same edge: `clr` wins, the compare is discarded and not counted. The history still shifts.
- **Saturation:** counters saturate at 2^CW−1. `err` stays set while `err_cnt` is saturated.

## Timing
- All outputs are registered. A compare on edge n is visible after edge n.
- After `nrst` deassertion every output is 0 and `state`=IDLE. Asserting `nrst` mid-CHECK forces this immediately.
- Sustained `vld=1` from IDLE with `en=1`:
  - Edge 1: IDLE→FILL.
  - Edges 2..TAPS+1: fill.
  - First compare on edge TAPS+2.
- `vld=0` edges are ignored entirely: no shift, no count, no compare.
- Throughput: one compare per clock.

## Configuration
- `MOY_CHK_ROUND_EN` defined: `exp = (sum + TAPS/2)>>log2(TAPS)`, round half up. Use this to check a rounding filter.
- Undefined (default): truncating `exp` as in Operation.

## Test plan
- **Constant input:** reset, `en=1`, `vld=1`, `e=m=8'h40` for 24 valid edges → `state`=CHECK, `chk_cnt`=20, `err`=0, `err_cnt`=0.
- **Ramp / truncation:** `e`=0,1,2,3 in FILL, then `m`=1 at the first compare → pass. With `MOY_CHK_ROUND_EN`, `m`=2 passes and `m`=1 fails with `first_exp`=2, `first_got`=1.
- **Error injection:** run the generator and filter; force `m` +1 on one sample, then +2 on a later one → `err`=1, `err_cnt`=2; `first_exp`/`first_got` hold the first mismatch only.
- **clr:**
  - `clr` pulsed on a mismatching edge → that compare is not counted, all results read 0, the next mismatch is captured as the first error.
  - `clr` on a matching edge → `chk_cnt`=0.
- **en drop and vld gaps:** `en`=0 mid-CHECK → IDLE next cycle, counters held. Re-enable → TAPS fill edges before the next compare. `vld` low for 3 cycles → no change to `chk_cnt`.
- **Saturation and reset:** preload by running with `CW=4` and 20 mismatches → `err_cnt`=15 and `err`=1. Assert `nrst` mid-CHECK → all outputs 0 and IDLE immediately.

Source files
------------

// File: rtl/moy_checker.sv
// moy_checker: self-checking monitor for the moving-average filter output.
// Keeps a TAPS-deep history of the filter input, computes the reference
// average and compares it against the filter output on every valid edge.
// Mismatches are reported through a sticky flag, saturating counters and a
// first-error capture.
// Build option: define MOY_CHK_ROUND_EN to check a round-half-up filter;
// the default build checks a truncating filter.
module moy_checker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAPS  = 4,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             vld,
    input  logic             clr,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] m,
    output logic [1:0]       state,
    output logic             err,
    output logic [CW-1:0]    chk_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    localparam int unsigned LG = $clog2(TAPS);
    localparam int unsigned SW = WIDTH + LG;
    localparam int unsigned FW = LG + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StCheck = 2'd2
    } st_t;

    st_t              st_q;
    logic [FW-1:0]    fill_cnt;
    logic [WIDTH-1:0] h [TAPS];
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_adj;
    logic [WIDTH-1:0] exp_val;
    logic             shift;

    assign state = st_q;

    // History advances on every accepted sample outside IDLE; an en=0 edge
    // always lands in IDLE, so it never shifts.
    assign shift = en && vld && (st_q != StIdle);

    // Reference average from the history as it stood before this edge's shift
    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + SW'(h[k]);
        end
`ifdef MOY_CHK_ROUND_EN
        sum_adj = sum + SW'(TAPS / 2);
`else
        sum_adj = sum;
`endif
        exp_val = WIDTH'(sum_adj >> LG);
    end

    // Sample history shift register; deliberately unreset, it is refilled
    // before any compare uses it
    always_ff @(posedge clk) begin
        if (shift) begin
            h[0] <= e;
            for (int k = 1; k < TAPS; k++) begin
                h[k] <= h[k-1];
            end
        end
    end

    // Control FSM, compare and result registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st_q      <= StIdle;
            fill_cnt  <= '0;
            err       <= 1'b0;
            chk_cnt   <= '0;
            err_cnt   <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else begin
            if (!en) begin
                st_q <= StIdle;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        st_q     <= StFill;
                        fill_cnt <= '0;
                    end
                    StFill: begin
                        if (vld) begin
                            fill_cnt <= fill_cnt + 1'b1;
                            if (fill_cnt == FW'(TAPS - 1)) begin
                                st_q <= StCheck;
                            end
                        end
                    end
                    StCheck: begin
                        if (vld && !clr) begin
                            if (chk_cnt != '1) begin
                                chk_cnt <= chk_cnt + 1'b1;
                            end
                            if (m != exp_val) begin
                                err <= 1'b1;
                                if (err_cnt != '1) begin
                                    err_cnt <= err_cnt + 1'b1;
                                end
                                // err is clear only before the first error
                                if (!err) begin
                                    first_exp <= exp_val;
                                    first_got <= m;
                                end
                            end
                        end
                    end
                    default: st_q <= StIdle;
                endcase
            end
            // clr overrides any compare on the same edge
            if (clr) begin
                err       <= 1'b0;
                chk_cnt   <= '0;
                err_cnt   <= '0;
                first_exp <= '0;
                first_got <= '0;
            end
        end
    end

endmodule

// File: tb/tb_moy_checker.sv
// Randomised bench for moy_checker with a queue-based reference model.
// Instance a uses CW=16, instance b uses CW=4 to exercise saturation.
module tb_moy_checker;

    localparam int TAPS  = 4;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    logic       vld = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] e = '0;
    logic [7:0] m = '0;

    logic [1:0]  state_a, state_b;
    logic        err_a, err_b;
    logic [15:0] chk_a, errc_a;
    logic [3:0]  chk_b, errc_b;
    logic [7:0]  fe_a, fg_a, fe_b, fg_b;

    moy_checker #(.WIDTH(WIDTH), .TAPS(TAPS), .CW(16)) dut_a (
        .clk(clk), .nrst(nrst), .en(en), .vld(vld), .clr(clr), .e(e), .m(m),
        .state(state_a), .err(err_a), .chk_cnt(chk_a), .err_cnt(errc_a),
        .first_exp(fe_a), .first_got(fg_a)
    );

    moy_checker #(.WIDTH(WIDTH), .TAPS(TAPS), .CW(4)) dut_b (
        .clk(clk), .nrst(nrst), .en(en), .vld(vld), .clr(clr), .e(e), .m(m),
        .state(state_b), .err(err_b), .chk_cnt(chk_b), .err_cnt(errc_b),
        .first_exp(fe_b), .first_got(fg_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int q[$];
    bit active;
    int nfill;
    int mchk, merr, mfe, mfg;
    bit merrf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    function automatic int model_exp();
        int s = 0;
        foreach (q[i]) s += q[i];
`ifdef MOY_CHK_ROUND_EN
        return (s + TAPS / 2) / TAPS;
`else
        return s / TAPS;
`endif
    endfunction

    function automatic int sat(input int v, input int cw);
        int mx = (1 << cw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        active = 0; nfill = 0;
        mchk = 0; merr = 0; merrf = 0; mfe = 0; mfg = 0;
    endtask

    task automatic model_edge();
        int x;
        if (!en) begin
            active = 0;
        end else if (!active) begin
            active = 1;
            nfill = 0;
        end else if (vld) begin
            if (nfill >= TAPS && !clr) begin
                x = model_exp();
                mchk++;
                if (int'(m) != x) begin
                    if (!merrf) begin
                        mfe = x;
                        mfg = int'(m);
                    end
                    merrf = 1;
                    merr++;
                end
            end
            q.push_front(int'(e));
            if (q.size() > TAPS) void'(q.pop_back());
            if (nfill < TAPS) nfill++;
        end
        if (clr) begin
            mchk = 0; merr = 0; merrf = 0; mfe = 0; mfg = 0;
        end
    endtask

    function automatic int model_state();
        if (!active) return 0;
        return (nfill < TAPS) ? 1 : 2;
    endfunction

    task automatic check_all();
        check("state_a", 32'(state_a), model_state());
        check("state_b", 32'(state_b), model_state());
        check("err_a", 32'(err_a), 32'(merrf));
        check("err_b", 32'(err_b), 32'(merrf));
        check("chk_a", 32'(chk_a), sat(mchk, 16));
        check("chk_b", 32'(chk_b), sat(mchk, 4));
        check("errc_a", 32'(errc_a), sat(merr, 16));
        check("errc_b", 32'(errc_b), sat(merr, 4));
        check("first_exp", 32'(fe_a), mfe);
        check("first_got", 32'(fg_a), mfg);
        check("first_exp_b", 32'(fe_b), mfe);
        check("first_got_b", 32'(fg_b), mfg);
    endtask

    task automatic step(input bit en_i, input bit vld_i, input bit clr_i,
                        input int e_i, input int m_i);
        @(negedge clk);
        en = en_i; vld = vld_i; clr = clr_i;
        e = e_i[7:0]; m = m_i[7:0];
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic refill();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) step(1, 1, 0, $urandom_range(255), 0);
    endtask

    initial begin
        int fx, r, cbefore;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) nrst = 1'b1;

        // Constant input: one enabling edge, then 24 valid edges
        step(1, 0, 0, 0, 0);
        repeat (24) step(1, 1, 0, 'h40, 'h40);
        check("const_state", 32'(state_a), 2);
        check("const_chk", 32'(chk_a), 20);
        check("const_err", 32'(errc_a), 0);

        // en drop mid-CHECK: IDLE, counters held
        step(0, 0, 0, 0, 0);
        check("drop_state", 32'(state_a), 0);
        check("drop_chk", 32'(chk_a), 20);

        // Ramp 0..3 then first compare
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, i, 0);
`ifdef MOY_CHK_ROUND_EN
        step(1, 1, 0, 4, 2);
`else
        step(1, 1, 0, 4, 1);
`endif
        check("ramp_pass", 32'(err_a), 0);

        // Ramp again with the other value, which must fail
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, i, 0);
`ifdef MOY_CHK_ROUND_EN
        step(1, 1, 0, 4, 1);
        check("ramp_fexp", 32'(fe_a), 2);
        check("ramp_fgot", 32'(fg_a), 1);
`else
        step(1, 1, 0, 4, 2);
        check("ramp_fexp", 32'(fe_a), 1);
        check("ramp_fgot", 32'(fg_a), 2);
`endif
        check("ramp_err", 32'(err_a), 1);

        // Error injection: +1 at sample 5, +2 at sample 15
        step(1, 0, 1, 0, 0);
        fx = 0;
        for (int i = 0; i < 30; i++) begin
            r = model_exp();
            if (i == 5) fx = r;
            step(1, 1, 0, $urandom_range(255), r + ((i == 5) ? 1 : (i == 15) ? 2 : 0));
        end
        check("inj_err", 32'(err_a), 1);
        check("inj_cnt", 32'(errc_a), 2);
        check("inj_fexp", 32'(fe_a), 32'(fx));
        check("inj_fgot", 32'(fg_a), 32'((fx + 1) % 256));

        // clr on a mismatching edge, then a new first error
        step(1, 1, 1, $urandom_range(255), model_exp() + 1);
        check("clr_chk", 32'(chk_a), 0);
        check("clr_errc", 32'(errc_a), 0);
        check("clr_err", 32'(err_a), 0);
        r = model_exp();
        step(1, 1, 0, $urandom_range(255), r + 3);
        check("clr_refexp", 32'(fe_a), 32'(r));
        check("clr_refgot", 32'(fg_a), 32'((r + 3) % 256));
        step(1, 1, 1, $urandom_range(255), model_exp());
        check("clr_match_chk", 32'(chk_a), 0);

        // vld gaps
        step(1, 1, 0, $urandom_range(255), model_exp());
        cbefore = int'(chk_a);
        repeat (3) step(1, 0, 0, $urandom_range(255), $urandom_range(255));
        check("gap_chk", 32'(chk_a), 32'(cbefore));

        // Re-enable needs TAPS fill edges before a compare
        refill();
        check("refill_chk", 32'(chk_a), 32'(cbefore));
        check("refill_state", 32'(state_a), 2);

        // Saturation with 20 mismatches on the CW=4 instance
        step(1, 0, 1, 0, 0);
        repeat (20) step(1, 1, 0, $urandom_range(255), model_exp() + 1);
        check("sat_errc_b", 32'(errc_b), 15);
        check("sat_chk_b", 32'(chk_b), 15);
        check("sat_err_b", 32'(err_b), 1);
        check("sat_errc_a", 32'(errc_a), 20);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = model_exp();
            if ($urandom_range(9) == 0) r = r + $urandom_range(1, 5);
            step($urandom_range(19) != 0, $urandom_range(3) != 0, $urandom_range(29) == 0,
                 $urandom_range(255), r);
        end

        // Asynchronous reset mid-CHECK
        refill();
        repeat (2) step(1, 1, 0, $urandom_range(255), model_exp() + 1);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1 model_reset();
        check_all();
        check("rst_state", 32'(state_a), 0);
        check("rst_errc", 32'(errc_a), 0);
        @(negedge clk) nrst = 1'b1;
        step(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
